// File: rtl/viterbi_tc_harness.sv
// Test harness around a serial decoder: shifts a parallel test word out as symbols,
// collects the returned bits into a result word and shows it on 7-segment digits.
// Optional COLLECT watchdog is built only when VTB_TIMEOUT_EN is defined.
module viterbi_tc_harness #(
    parameter int SIZE_DATA_IN  = 16,
    parameter int SIZE_DATA_OUT = 8,
    parameter int SIZE_PISO     = 2,
    parameter int SIZE_SIPO     = 1,
    parameter int SIZE_7SEG     = 7,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic                                     i_start,
    input  logic [SIZE_DATA_IN-1:0]                  i_data,
    output logic [SIZE_PISO-1:0]                     o_sym,
    output logic                                     o_sym_valid,
    input  logic [SIZE_SIPO-1:0]                     i_dut_bits,
    input  logic                                     i_dut_valid,
    output logic [SIZE_DATA_OUT-1:0]                 o_data_out,
    output logic [(SIZE_DATA_OUT/4)*SIZE_7SEG-1:0]   o_hex,
    output logic                                     o_done_PISO,
    output logic                                     o_done_SIPO,
    output logic                                     o_busy,
    output logic                                     o_timeout
);

    localparam int NUM_HEX = SIZE_DATA_OUT / 4;
    localparam int N_SYM   = SIZE_DATA_IN / SIZE_PISO;
    localparam int N_BEAT  = SIZE_DATA_OUT / SIZE_SIPO;
    localparam int SYM_CW  = $clog2(N_SYM + 1);
    localparam int BEAT_CW = $clog2(N_BEAT + 1);
    localparam int HEX_W   = NUM_HEX * SIZE_7SEG;

    if ((SIZE_DATA_IN % SIZE_PISO) != 0 || (SIZE_DATA_OUT % SIZE_SIPO) != 0 ||
        (SIZE_DATA_OUT % 4) != 0 || SIZE_7SEG != 7 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("viterbi_tc_harness: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COLLECT,
        S_DONE
    } state_e;

    state_e                     state_q,     state_d;
    logic                       sync1_q,     sync1_d;
    logic                       sync2_q,     sync2_d;
    logic                       sync3_q,     sync3_d;
    logic                       edge_q,      edge_d;
    logic [SIZE_DATA_IN-1:0]    piso_q,      piso_d;
    logic [SIZE_DATA_OUT-1:0]   sipo_q,      sipo_d;
    logic [SIZE_DATA_OUT-1:0]   data_out_q,  data_out_d;
    logic [SYM_CW-1:0]          sym_cnt_q,   sym_cnt_d;
    logic [BEAT_CW-1:0]         beat_cnt_q,  beat_cnt_d;
    logic                       done_piso_q, done_piso_d;
    logic                       done_sipo_q, done_sipo_d;
    logic [HEX_W-1:0]           hex_q,       hex_d;
    logic                       busy;
    logic                       beat_take;

`ifdef VTB_TIMEOUT_EN
    localparam int TO_CW = $clog2(TIMEOUT_CYC + 1);
    logic [TO_CW-1:0]           to_cnt_q,    to_cnt_d;
    logic                       timeout_q,   timeout_d;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d is given its held value first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        sync1_d     = i_start;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        edge_d      = sync2_q & ~sync3_q;
        piso_d      = piso_q;
        sipo_d      = sipo_q;
        data_out_d  = data_out_q;
        sym_cnt_d   = sym_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        done_piso_d = done_piso_q;
        done_sipo_d = done_sipo_q;
`ifdef VTB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_d   = timeout_q;
`endif

        busy      = (state_q == S_SHIFT) || (state_q == S_COLLECT);
        beat_take = busy && i_dut_valid && !done_sipo_q;

        // Returned beats are collected in parallel with symbol shifting; beats past a full word are dropped.
        if (beat_take) begin
            sipo_d     = (sipo_q << SIZE_SIPO) | SIZE_DATA_OUT'(i_dut_bits);
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == BEAT_CW'(N_BEAT - 1)) begin
                data_out_d  = sipo_d;
                done_sipo_d = 1'b1;
            end
        end
`ifdef VTB_TIMEOUT_EN
        if (busy && i_dut_valid) begin
            to_cnt_d = '0;
        end
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (edge_q) begin
                    state_d     = S_SHIFT;
                    piso_d      = i_data;
                    sipo_d      = '0;
                    sym_cnt_d   = '0;
                    beat_cnt_d  = '0;
                    done_piso_d = 1'b0;
                    done_sipo_d = 1'b0;
`ifdef VTB_TIMEOUT_EN
                    to_cnt_d    = '0;
                    timeout_d   = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                piso_d    = piso_q << SIZE_PISO;
                sym_cnt_d = sym_cnt_q + 1'b1;
                if (sym_cnt_q == SYM_CW'(N_SYM - 1)) begin
                    done_piso_d = 1'b1;
                    state_d     = done_sipo_d ? S_DONE : S_COLLECT;
`ifdef VTB_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end
            end
            S_COLLECT: begin
                if (done_sipo_d) begin
                    state_d = S_DONE;
                end
`ifdef VTB_TIMEOUT_EN
                else if (!i_dut_valid) begin
                    if (to_cnt_q == TO_CW'(TIMEOUT_CYC - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        hex_d = '0;
        for (int k = 0; k < NUM_HEX; k++) begin
            hex_d[k*SIZE_7SEG +: SIZE_7SEG] = seg7(data_out_d[4*k +: 4]);
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the reset clears the shift registers too.
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            edge_q      <= 1'b0;
            piso_q      <= '0;
            sipo_q      <= '0;
            data_out_q  <= '0;
            sym_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            done_piso_q <= 1'b0;
            done_sipo_q <= 1'b0;
            hex_q       <= {NUM_HEX{7'b1000000}};
`ifdef VTB_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            edge_q      <= edge_d;
            piso_q      <= piso_d;
            sipo_q      <= sipo_d;
            data_out_q  <= data_out_d;
            sym_cnt_q   <= sym_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            done_piso_q <= done_piso_d;
            done_sipo_q <= done_sipo_d;
            hex_q       <= hex_d;
`ifdef VTB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign o_sym       = piso_q[SIZE_DATA_IN-1 -: SIZE_PISO];
    assign o_sym_valid = (state_q == S_SHIFT);
    assign o_busy      = busy;
    assign o_data_out  = data_out_q;
    assign o_hex       = hex_q;
    assign o_done_PISO = done_piso_q;
    assign o_done_SIPO = done_sipo_q;
`ifdef VTB_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: doc/viterbi_tc_harness.md
VITERBI_TC_HARNESS -- requirements
Module: viterbi_tc_harness

Interface
REQ-001 Parameter SIZE_DATA_IN, default 16: parallel test word width; SHALL be a multiple of SIZE_PISO.
REQ-002 Parameter SIZE_DATA_OUT, default 8: collected result width; SHALL be a multiple of SIZE_SIPO and of 4.
REQ-003 Parameter SIZE_PISO, default 2: symbol width driven to the DUT per beat.
REQ-004 Parameter SIZE_SIPO, default 1: bits accepted from the DUT per beat.
REQ-005 Parameter SIZE_7SEG, default 7: segment count per digit; fixed at 7.
REQ-006 Parameter TIMEOUT_CYC, default 1024: watchdog limit in cycles; only used with VTB_TIMEOUT_EN.
REQ-007 Derived NUM_HEX = SIZE_DATA_OUT/4, N_SYM = SIZE_DATA_IN/SIZE_PISO, N_BEAT = SIZE_DATA_OUT/SIZE_SIPO.
REQ-008 Single clock and synchronous active-low reset, as fixed for this block.
REQ-009 i_clk  in  1  clock, all logic rising-edge.
REQ-010 i_rst_n  in  1  synchronous active-low reset.
REQ-011 i_start  in  1  level start request from a switch, asynchronous to i_clk.
REQ-012 i_data  in  SIZE_DATA_IN  test word, sampled at load.
REQ-013 o_sym  out  SIZE_PISO  serial symbol to the DUT.
REQ-014 o_sym_valid  out  1  o_sym qualifier.
REQ-015 i_dut_bits  in  SIZE_SIPO  decoded bits from the DUT.
REQ-016 i_dut_valid  in  1  i_dut_bits qualifier.
REQ-017 o_data_out  out  SIZE_DATA_OUT  last completed result word.
REQ-018 o_hex  out  NUM_HEX*SIZE_7SEG  digit k occupies bits [7k+6:7k], active-low segments {g,f,e,d,c,b,a}.
REQ-019 o_done_PISO / o_done_SIPO / o_busy / o_timeout  out  1 each  status flags.

Function
REQ-020 i_start SHALL pass through a 2-flop synchronizer followed by a registered rising-edge detector; one run is triggered per 0->1 transition, and holding i_start high SHALL NOT retrigger.
REQ-021 The FSM SHALL have the states IDLE, SHIFT, COLLECT and DONE.
REQ-022 IDLE or DONE with a start edge: load i_data into the PISO register, clear the SIPO register, beat counters and both done flags, then go to SHIFT.
REQ-023 SHIFT SHALL assert o_sym_valid for exactly N_SYM consecutive cycles, driving o_sym MSB-first (top SIZE_PISO bits) and shifting left each cycle.
REQ-024 The first o_sym_valid SHALL appear on the cycle after the detected edge.
REQ-025 After the last symbol, o_done_PISO SHALL set, and the FSM SHALL go to COLLECT if fewer than N_BEAT beats have been received, else to DONE.
REQ-026 In SHIFT and COLLECT, each i_dut_valid cycle SHALL shift in the beat: sipo <= {sipo, i_dut_bits}, first beat ending up most significant.
REQ-027 On the N_BEAT-th beat, o_data_out SHALL update with the assembled word on the next edge and o_done_SIPO SHALL set; excess beats in the same run are ignored.
REQ-028 If the N_BEAT-th beat occurs during SHIFT, the FSM SHALL complete SHIFT and then go directly to DONE.
REQ-029 o_busy SHALL be 1 in SHIFT and COLLECT; start edges in these states SHALL be ignored.
REQ-030 o_hex digit k SHALL show o_data_out[4k+3:4k] as registered hex 0-F, e.g. 0=1000000, 5=0010010, A=0001000.
REQ-031 o_done_PISO and o_done_SIPO SHALL be sticky until the next start edge or reset.
REQ-032 i_dut_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-033 On i_rst_n=0 at a clock edge: state IDLE, synchronizer and edge flops 0, all registers and counters 0, o_sym=0, o_sym_valid=0, all flags 0, o_data_out=0, every digit 1000000; this SHALL apply in every state, including mid-run.

Configuration
REQ-034 With the macro VTB_TIMEOUT_EN defined, a counter SHALL clear on each i_dut_valid and on entry to COLLECT. In COLLECT, TIMEOUT_CYC cycles without i_dut_valid SHALL set sticky o_timeout, go to DONE, and leave o_data_out unchanged with o_done_SIPO=0.
REQ-035 Without VTB_TIMEOUT_EN: no counter is built, o_timeout is tied to 0, and COLLECT waits indefinitely.

Verification
REQ-036 i_data=16'hB4C3, start 0->1 -> o_sym 2,3,1,0,3,0,0,3 over 8 consecutive valid cycles; o_done_PISO=1 after the 8th symbol.
REQ-037 DUT beats 1,0,1,0,0,1,0,1 -> o_data_out=8'hA5, o_done_SIPO=1, digit1=0001000, digit0=0010010, o_busy=0.
REQ-038 i_start held high for 100 cycles, then a second 0->1 during SHIFT -> exactly one run of 8 symbols.
REQ-039 i_rst_n=0 at the 4th symbol -> next cycle o_sym_valid=0, state IDLE, all outputs at reset values; a new start gives a clean 8-symbol run.
REQ-040 VTB_TIMEOUT_EN with TIMEOUT_CYC=16, only 3 beats sent -> o_timeout=1 16 cycles after the last beat, o_data_out unchanged; without the macro, o_busy stays 1.
